// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared definitions for both halves of the async FIFO:
//                default geometry, pointer width and Gray-code helpers.
//  Revision    : 1.0  - initial release
// ============================================================================
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_ADDR_WIDTH = $clog2(DEF_FIFO_DEPTH);
    // Pointers carry one extra MSB so a full FIFO can be told apart from an empty one.
    localparam int DEF_PTR_WIDTH  = DEF_ADDR_WIDTH + 1;

    // Helpers work on a wide word; callers zero-extend their pointer and
    // truncate the result. Zero upper bits leave the low bits of both
    // conversions unchanged, so one function serves every pointer width.
    localparam int C_PTR_MAX_WIDTH = 32;
    typedef logic [C_PTR_MAX_WIDTH-1:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin[C_PTR_MAX_WIDTH-1] = gray[C_PTR_MAX_WIDTH-1];
        for (int i = C_PTR_MAX_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_ctrl_if
//  Description : Read-side bundle of the async FIFO: memory read port,
//                pointer exchange with the write domain and the consumer
//                valid/ready stream. master = read controller.
//  Revision    : 1.0  - initial release
// ============================================================================
interface fifo_rd_ctrl_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    localparam int PTR_WIDTH = ADDR_WIDTH + 1;

    logic [PTR_WIDTH-1:0]  wptr_gray;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [PTR_WIDTH-1:0]  rptr_gray;
    logic                  empty;
    logic [PTR_WIDTH-1:0]  level;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  wptr_gray, rdata, out_ready,
        output raddr, rptr_gray, empty, level, out_data, out_valid
    );

    modport slave (
        output wptr_gray, rdata, out_ready,
        input  raddr, rptr_gray, empty, level, out_data, out_valid
    );

endinterface
`default_nettype wire

// File: rtl/fifo_gray_sync.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_gray_sync
//  Description : Two-flop synchronizer for a Gray-coded pointer crossing
//                into this clock domain. Gray coding guarantees at most one
//                bit changes per update, so the captured value is always
//                either the old or the new pointer.
//  Revision    : 1.0  - initial release
// ============================================================================
module fifo_gray_sync #(
    parameter int WIDTH = 4
) (
    input  wire             clk,
    input  wire             rst_n,
    input  wire [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // First stage may go metastable; second stage hands a settled value on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_ctrl
//  Description : Read-side controller of the async FIFO. Synchronises the
//                write pointer, tracks empty/level, addresses the memory and
//                drains words into a registered valid/ready output stage.
//  Revision    : 1.0  - initial release
// ============================================================================
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  wire            clk,
    input  wire            rst_n,
    fifo_rd_ctrl_if.master bus
);

    localparam int PTR_WIDTH = ADDR_WIDTH + 1;

    // Geometry must be a power of two so the address is simply the pointer LSBs.
    generate
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
            (ADDR_WIDTH != $clog2(FIFO_DEPTH))) begin : g_bad_geometry
            $error("fifo_rd_ctrl: FIFO_DEPTH must be a power of 2 >= 2 and ADDR_WIDTH = clog2(FIFO_DEPTH)");
        end
    endgenerate

    logic [PTR_WIDTH-1:0]  w_wq2;
    logic [PTR_WIDTH-1:0]  r_rptr_bin;
    logic [PTR_WIDTH-1:0]  r_rptr_gray;
    logic [PTR_WIDTH-1:0]  w_rptr_inc;
    logic [PTR_WIDTH-1:0]  w_rptr_next;
    logic                  r_empty;
    logic                  w_empty_next;
    logic                  w_pop;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;

    fifo_gray_sync #(
        .WIDTH (PTR_WIDTH)
    ) u_wptr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.wptr_gray),
        .q     (w_wq2)
    );

    // Pop whenever a word is visible and the output stage is free or being emptied.
    always_comb begin
        w_pop        = !r_empty && (!r_out_valid || bus.out_ready);
        w_rptr_inc   = r_rptr_bin + PTR_WIDTH'(1);
        w_rptr_next  = w_pop ? w_rptr_inc : r_rptr_bin;
        // Compare in Gray against the synchronised write pointer; looking at
        // the post-pop pointer lets back-to-back pops stop exactly at empty.
        w_empty_next = (bin2gray(C_PTR_MAX_WIDTH'(w_rptr_next)) ==
                        C_PTR_MAX_WIDTH'(w_wq2));
    end

    // Read pointer (binary and Gray copies) and the registered empty flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rptr_bin  <= '0;
            r_rptr_gray <= '0;
            r_empty     <= 1'b1;
        end else begin
            r_rptr_bin  <= w_rptr_next;
            r_rptr_gray <= PTR_WIDTH'(bin2gray(C_PTR_MAX_WIDTH'(w_rptr_next)));
            r_empty     <= w_empty_next;
        end
    end

    // Output stage: load on pop, clear once accepted, otherwise hold steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.rdata;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.raddr     = r_rptr_bin[ADDR_WIDTH-1:0];
    assign bus.rptr_gray = r_rptr_gray;
    assign bus.empty     = r_empty;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    // Modular subtract keeps the count right across pointer wrap.
    assign bus.level     = PTR_WIDTH'(gray2bin(C_PTR_MAX_WIDTH'(w_wq2)) -
                                      C_PTR_MAX_WIDTH'(r_rptr_bin));

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_ctrl
//  Description : Self-checking bench for fifo_rd_ctrl: vector table, corner
//                sequences and random traffic against a word-count model.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_fifo_rd_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];

    fifo_rd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    assign bus.rdata = mem[bus.raddr];

    fifo_rd_ctrl #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: counts of words written, words the reader can see, words popped.
    int            wcnt;
    int            m_seen1, m_seen2;
    int            m_rcnt;
    bit            m_empty, m_valid;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_words [$];

    typedef struct {
        logic          wr;
        logic [DW-1:0] wdata;
        logic          ready;
        logic          empty;
        logic          valid;
        logic [DW-1:0] data;
        logic [3:0]    level;
        logic [2:0]    raddr;
    } vec_t;
    vec_t tbl [13];

    function automatic logic [3:0] gray4(input int n);
        logic [3:0] b;
        b = 4'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic m_reset();
        m_seen1 = 0;
        m_seen2 = 0;
        m_rcnt  = 0;
        m_empty = 1'b1;
        m_valid = 1'b0;
        m_data  = '0;
        m_words.delete();
        wcnt    = 0;
        bus.wptr_gray = '0;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        mem[wcnt % DEPTH] = d;
        m_words.push_back(d);
        wcnt++;
        bus.wptr_gray = gray4(wcnt);
    endtask

    // One clock: predict from pre-edge state, then compare every output.
    task automatic step(input string tag);
        bit pop;
        bit nxt_empty;
        pop       = !m_empty && (!m_valid || bus.out_ready);
        nxt_empty = ((m_rcnt + (pop ? 1 : 0)) == m_seen2);
        @(posedge clk); #1;
        if (pop) begin
            m_data  = m_words.pop_front();
            m_valid = 1'b1;
            m_rcnt++;
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
        end
        m_empty = nxt_empty;
        m_seen2 = m_seen1;
        m_seen1 = wcnt;
        check(tag,
              32'({bus.empty, bus.out_valid, bus.out_data, bus.level, bus.raddr, bus.rptr_gray}),
              32'({m_empty, m_valid, m_data, 4'(m_seen2 - m_rcnt), 3'(m_rcnt % DEPTH), gray4(m_rcnt)}));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int seq;
        logic [3:0] prev_g;
        logic [3:0] prev_lvl;

        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 3'd0};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 4'd1, 3'd0};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'd1, 3'd0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 4'd0, 3'd1};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 4'd0, 3'd1};
        tbl[5]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'hA5, 4'd0, 3'd1};
        tbl[6]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'hA5, 4'd1, 3'd1};
        tbl[7]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'hA5, 4'd2, 3'd1};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 4'd2, 3'd2};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 4'd2, 3'd2};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 4'd1, 3'd3};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 4'd0, 3'd4};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h33, 4'd0, 3'd4};

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        bus.out_ready = 1'b0;
        bus.wptr_gray = 4'd3;
        rst_n         = 1'b0;

        // Reset holds everything idle even with a non-zero write pointer.
        repeat (3) @(posedge clk);
        #1;
        check("rst_empty", 32'(bus.empty), 32'(1'b1));
        check("rst_valid", 32'(bus.out_valid), 32'(1'b0));
        check("rst_raddr", 32'(bus.raddr), 32'(3'd0));
        check("rst_level", 32'(bus.level), 32'(4'd0));
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            n++;
            if (!bus.empty) break;
        end
        check("empty_fall_edge", 32'(n), 32'(3));

        // Vector table: single word, then backpressure with three words.
        do_reset();
        bus.out_ready = 1'b1;
        repeat (3) step("idle");
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].wr) write_word(tbl[i].wdata);
            bus.out_ready = tbl[i].ready;
            step("table_model");
            check($sformatf("table[%0d]", i),
                  32'({bus.empty, bus.out_valid, bus.out_data, bus.level, bus.raddr}),
                  32'({tbl[i].empty, tbl[i].valid, tbl[i].data, tbl[i].level, tbl[i].raddr}));
        end

        // Wrap: 20 words in order, Gray pointer moves one bit at a time.
        do_reset();
        bus.out_ready = 1'b1;
        seq    = 0;
        prev_g = bus.rptr_gray;
        for (int k = 0; k < 200; k++) begin
            if (wcnt < 20 && (wcnt - m_rcnt) < DEPTH) write_word(8'(wcnt));
            step("wrap_model");
            if (bus.rptr_gray != prev_g)
                check("rptr_gray_step", 32'($countones(bus.rptr_gray ^ prev_g)), 32'(1));
            prev_g = bus.rptr_gray;
            if (bus.out_valid) begin
                check("wrap_order", 32'(bus.out_data), 32'(seq));
                seq++;
            end
            if (seq == 20 && !bus.out_valid) break;
        end
        check("wrap_count", 32'(seq), 32'(20));
        check("wrap_final_gray", 32'(bus.rptr_gray), 32'(gray4(20)));
        check("wrap_final_raddr", 32'(bus.raddr), 32'(4));

        // Full: eight words outstanding behind the output register.
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            write_word(8'($urandom));
            step("full_fill");
        end
        repeat (4) step("full_settle");
        write_word(8'($urandom));
        repeat (3) step("full_settle");
        check("full_level", 32'(bus.level), 32'(DEPTH));
        check("full_empty", 32'(bus.empty), 32'(1'b0));
        bus.out_ready = 1'b1;
        prev_lvl = bus.level;
        for (int k = 0; k < 30; k++) begin
            step("drain_model");
            if (bus.level != prev_lvl)
                check("drain_step", 32'(prev_lvl - bus.level), 32'(1));
            prev_lvl = bus.level;
            if (bus.empty && !bus.out_valid) break;
        end
        check("drain_level", 32'(bus.level), 32'(0));
        check("drain_empty", 32'(bus.empty), 32'(1'b1));

        // Reset mid-drain drops the in-flight word at once.
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            write_word(8'(8'h40 + i));
            step("mid_fill");
        end
        repeat (5) step("mid_settle");
        check("pre_rst_valid", 32'(bus.out_valid), 32'(1'b1));
        check("pre_rst_level", 32'(bus.level), 32'(3));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'(1'b0));
        check("async_rst_gray", 32'(bus.rptr_gray), 32'(4'd0));
        check("async_rst_empty", 32'(bus.empty), 32'(1'b1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (6) step("post_rst");
        check("post_rst_no_pop", 32'({bus.out_valid, bus.rptr_gray}), 32'(5'd0));

        // Random traffic with backpressure bursts.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ((c % 200) < 40) bus.out_ready = ($urandom_range(0, 3) == 0);
            else                bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1 && (wcnt - m_rcnt) < DEPTH)
                write_word(8'($urandom));
            step("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
